// File: rtl/irq_pkg.sv
//------------------------------------------------------------------------------
// Module   : irq_pkg
// Purpose  : Shared types and constants for the interrupt controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_ACK_SRC = 2'd2,
        ST_GAP     = 2'd3
    } irq_state_t;

    localparam logic [1:0] c_OFF_MASK    = 2'd0;
    localparam logic [1:0] c_OFF_PENDING = 2'd1;
    localparam logic [1:0] c_OFF_STATUS  = 2'd2;
    localparam logic [1:0] c_OFF_COUNT   = 2'd3;

    localparam logic [7:0] c_DEFAULT_BASE_ADDR = 8'hD0;

endpackage

`default_nettype wire

// File: rtl/irq_arbiter.sv
//------------------------------------------------------------------------------
// Module   : irq_arbiter
// Purpose  : Picks the first pending source searching upward from a pointer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] i_pending,
    input  logic [ID_W-1:0]    i_pointer,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id
);

    int              v_idx;
    logic [ID_W-1:0] v_sel;

    // Scan from the far end so the candidate closest to the pointer is written last.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        v_idx   = 0;
        v_sel   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            v_idx = int'(i_pointer) + k;
            if (v_idx >= NUM_SRC) begin
                v_idx = v_idx - NUM_SRC;
            end
            v_sel = ID_W'(v_idx);
            if (i_pending[v_sel]) begin
                o_valid = 1'b1;
                o_id    = v_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
//------------------------------------------------------------------------------
// Module   : irq_controller
// Purpose  : Bus-mapped interrupt controller with mask, pending, status and
//            delivery counter; IRQ_ROUND_ROBIN_EN selects round-robin arbitration.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_controller
    import irq_pkg::*;
#(
    parameter int         NUM_SRC   = 3,
    parameter logic [7:0] BASE_ADDR = c_DEFAULT_BASE_ADDR
) (
    input  logic               CLK,
    input  logic               RESET,
    inout  wire  [7:0]         BUS_DATA,
    input  logic [7:0]         BUS_ADDR,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] SRC_IRQ_RAISE,
    output logic [NUM_SRC-1:0] SRC_IRQ_ACK,
    output logic [NUM_SRC-1:0] CPU_IRQ_RAISE,
    input  logic [NUM_SRC-1:0] CPU_IRQ_ACK
);

    localparam int c_ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    irq_state_t         r_state;
    logic [c_ID_W-1:0]  r_id;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_cpu_raise;
    logic [NUM_SRC-1:0] r_src_ack;
    logic [7:0]         r_count;
    logic               r_rd_en;
    logic [7:0]         r_rd_data;

    logic [NUM_SRC-1:0] w_pending;
    logic               w_arb_valid;
    logic [c_ID_W-1:0]  w_arb_id;
    logic [c_ID_W-1:0]  w_arb_ptr;
    logic [7:0]         w_offset;
    logic               w_addr_hit;
    logic [7:0]         w_wr_data;
    logic [7:0]         w_rd_value;
    logic               w_unused;

    assign w_offset   = BUS_ADDR - BASE_ADDR;
    assign w_addr_hit = (w_offset < 8'd4);
    assign w_wr_data  = BUS_DATA;
    assign w_unused   = ^w_wr_data;
    assign w_pending  = SRC_IRQ_RAISE & r_mask;

`ifdef IRQ_ROUND_ROBIN_EN
    localparam logic c_RR_FLAG = 1'b1;
    logic [c_ID_W-1:0] r_rr_ptr;

    // Next search starts just above the source that was last delivered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rr_ptr <= '0;
        end else if (r_state == ST_ACK_SRC) begin
            r_rr_ptr <= (r_id == c_ID_W'(NUM_SRC - 1)) ? '0 : r_id + c_ID_W'(1);
        end
    end

    assign w_arb_ptr = r_rr_ptr;
`else
    localparam logic c_RR_FLAG = 1'b0;
    assign w_arb_ptr = '0;
`endif

    irq_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (c_ID_W)
    ) u_arbiter (
        .i_pending (w_pending),
        .i_pointer (w_arb_ptr),
        .o_valid   (w_arb_valid),
        .o_id      (w_arb_id)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_id        <= '0;
            r_cpu_raise <= '0;
            r_src_ack   <= '0;
            r_count     <= 8'd0;
        end else begin
            r_src_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_id        <= w_arb_id;
                        r_cpu_raise <= NUM_SRC'(1) << w_arb_id;
                        r_state     <= ST_ASSERT;
                    end
                end
                // Held regardless of mask or source level until the CPU acks this id.
                ST_ASSERT: begin
                    if (CPU_IRQ_ACK[r_id]) begin
                        r_cpu_raise <= '0;
                        r_src_ack   <= NUM_SRC'(1) << r_id;
                        r_state     <= ST_ACK_SRC;
                    end
                end
                ST_ACK_SRC: begin
                    r_count <= r_count + 8'd1;
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mask    <= '1;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending;
            if (BUS_WE && w_addr_hit && (w_offset[1:0] == c_OFF_MASK)) begin
                r_mask <= w_wr_data[NUM_SRC-1:0];
            end
        end
    end

    always_comb begin
        w_rd_value = 8'h00;
        case (w_offset[1:0])
            c_OFF_MASK:    w_rd_value = 8'(r_mask);
            c_OFF_PENDING: w_rd_value = 8'(r_pending);
            c_OFF_STATUS:  w_rd_value = {(r_state != ST_IDLE), c_RR_FLAG, 4'b0000, 2'(r_id)};
            c_OFF_COUNT:   w_rd_value = r_count;
            default:       w_rd_value = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd_en   <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            r_rd_en   <= w_addr_hit && !BUS_WE;
            r_rd_data <= w_rd_value;
        end
    end

    assign BUS_DATA      = r_rd_en ? r_rd_data : 8'hzz;
    assign CPU_IRQ_RAISE = r_cpu_raise;
    assign SRC_IRQ_ACK   = r_src_ack;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_irq_controller
// Purpose  : Directed self-checking bench for irq_controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_irq_controller;

    localparam logic [7:0] c_BASE = 8'hD0;
`ifdef IRQ_ROUND_ROBIN_EN
    localparam logic [7:0] c_RR = 8'h40;
`else
    localparam logic [7:0] c_RR = 8'h00;
`endif

    logic       CLK;
    logic       RESET;
    wire  [7:0] BUS_DATA;
    logic [7:0] r_addr;
    logic       r_we;
    logic [7:0] r_drv;
    logic       r_oe;
    logic [2:0] r_raise;
    logic [2:0] w_src_ack;
    logic [2:0] w_cpu_raise;
    logic [2:0] r_ack;

    int n_tests;
    int n_fail;

    assign BUS_DATA = r_oe ? r_drv : 8'hzz;

    // Released bus floats to all ones so high-Z is observable.
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (BUS_DATA[g]);
    end

    irq_controller #(
        .NUM_SRC   (3),
        .BASE_ADDR (c_BASE)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUS_DATA      (BUS_DATA),
        .BUS_ADDR      (r_addr),
        .BUS_WE        (r_we),
        .SRC_IRQ_RAISE (r_raise),
        .SRC_IRQ_ACK   (w_src_ack),
        .CPU_IRQ_RAISE (w_cpu_raise),
        .CPU_IRQ_ACK   (r_ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET   = 1'b1;
        r_raise = 3'b000;
        r_ack   = 3'b000;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [7:0] data);
        r_addr = c_BASE + 8'(off);
        r_we   = 1'b1;
        r_drv  = data;
        r_oe   = 1'b1;
        tick();
        r_we   = 1'b0;
        r_oe   = 1'b0;
        r_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [1:0] off, input logic [7:0] exp, input string tag);
        r_addr = c_BASE + 8'(off);
        r_we   = 1'b0;
        tick();
        check(tag, BUS_DATA, exp);
        r_addr = 8'h00;
        tick();
        check("bus_release", BUS_DATA, 8'hFF);
    endtask

    task automatic wait_raise();
        for (int i = 0; i < 20 && w_cpu_raise == 3'b000; i++) begin
            tick();
        end
    endtask

    task automatic serve(input logic [2:0] exp, input bit drop);
        wait_raise();
        check("cpu_raise", w_cpu_raise, exp);
        r_ack = exp;
        tick();
        r_ack = 3'b000;
        check("src_ack", w_src_ack, exp);
        check("cpu_drop", w_cpu_raise, 3'b000);
        if (drop) begin
            r_raise = r_raise & ~exp;
        end
        tick();
        check("src_ack_one_cycle", w_src_ack, 3'b000);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        r_addr  = 8'h00;
        r_we    = 1'b0;
        r_drv   = 8'h00;
        r_oe    = 1'b0;
        RESET   = 1'b1;
        r_raise = 3'b000;
        r_ack   = 3'b000;
        tick();
        tick();
        check("rst_cpu_raise", w_cpu_raise, 3'b000);
        check("rst_src_ack", w_src_ack, 3'b000);
        check("rst_bus_hiz", BUS_DATA, 8'hFF);
        RESET = 1'b0;
        tick();
        bus_read(2'd0, 8'h07, "rst_mask");
        bus_read(2'd3, 8'h00, "rst_count");
        bus_read(2'd2, 8'h00 | c_RR, "rst_status");
        bus_read(2'd1, 8'h00, "rst_pending");

        // Single source, with a stray ack on another bit ignored.
        r_raise = 3'b010;
        tick();
        check("src1_latency", w_cpu_raise, 3'b010);
        r_ack = 3'b001;
        tick();
        r_ack = 3'b000;
        check("wrong_ack_no_src_ack", w_src_ack, 3'b000);
        check("wrong_ack_holds", w_cpu_raise, 3'b010);
        serve(3'b010, 1'b1);
        bus_read(2'd3, 8'h01, "count_one");

        // Fixed order 0 then 2, next raise four cycles after the ack.
        do_reset();
        r_raise = 3'b101;
        serve(3'b001, 1'b1);
        tick();
        check("gap_idle_no_raise", w_cpu_raise, 3'b000);
        tick();
        check("next_raise_m4", w_cpu_raise, 3'b100);
        bus_read(2'd2, 8'h82 | c_RR, "status_src2");
        serve(3'b100, 1'b1);
        bus_read(2'd3, 8'h02, "count_two");

        // Masked source stays invisible until unmasked.
        do_reset();
        bus_write(2'd0, 8'h01);
        r_raise = 3'b010;
        tick();
        tick();
        tick();
        check("masked_no_raise", w_cpu_raise, 3'b000);
        bus_read(2'd1, 8'h00, "masked_pending");
        bus_read(2'd0, 8'h01, "mask_readback");
        bus_write(2'd0, 8'h07);
        serve(3'b010, 1'b1);
        bus_write(2'd1, 8'h00);
        bus_read(2'd0, 8'h07, "ro_write_ignored");

        // Mask cleared and source dropped mid-service do not retract.
        do_reset();
        r_raise = 3'b001;
        wait_raise();
        bus_write(2'd0, 8'h00);
        r_raise = 3'b000;
        tick();
        check("mask_clear_holds", w_cpu_raise, 3'b001);
        serve(3'b001, 1'b1);
        bus_write(2'd0, 8'h07);

        // Request arriving during service waits for the next arbitration.
        r_raise = 3'b010;
        wait_raise();
        r_raise = 3'b011;
        tick();
        check("late_req_waits", w_cpu_raise, 3'b010);
        serve(3'b010, 1'b1);
        serve(3'b001, 1'b1);

        // Reset while asserting src2 abandons the interrupt.
        do_reset();
        bus_write(2'd0, 8'h05);
        r_raise = 3'b100;
        wait_raise();
        check("pre_reset_raise", w_cpu_raise, 3'b100);
        RESET = 1'b1;
        tick();
        check("reset_drops_raise", w_cpu_raise, 3'b000);
        check("reset_no_src_ack", w_src_ack, 3'b000);
        RESET   = 1'b0;
        r_raise = 3'b000;
        tick();
        check("reset_no_src_ack_after", w_src_ack, 3'b000);
        bus_read(2'd0, 8'h07, "reset_mask");

`ifdef IRQ_ROUND_ROBIN_EN
        do_reset();
        r_raise = 3'b111;
        serve(3'b001, 1'b0);
        serve(3'b010, 1'b0);
        serve(3'b100, 1'b0);
        serve(3'b001, 1'b0);
        r_raise = 3'b000;
        tick();
        tick();
`endif

        // Counter wrap after 256 deliveries.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            r_raise = 3'b001;
            serve(3'b001, 1'b1);
        end
        bus_read(2'd3, 8'hFF, "count_255");
        r_raise = 3'b001;
        serve(3'b001, 1'b1);
        bus_read(2'd3, 8'h00, "count_wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: number of interrupt sources (bit 0 = mouse, 1 = timer, 2 = switch).
REQ-002 SHALL have parameter BASE_ADDR, default 8'hD0: bus address of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.
REQ-003 CLK  input  1  single system clock; all logic on rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 BUS_DATA  inout  8  shared data bus; driven only during register reads, otherwise high-Z.
REQ-006 BUS_ADDR  input  8  shared address bus.
REQ-007 BUS_WE  input  1  bus write strobe.
REQ-008 SRC_IRQ_RAISE  input  NUM_SRC  level requests from peripherals; each held high until acknowledged.
REQ-009 SRC_IRQ_ACK  output  NUM_SRC  one-cycle acknowledge pulse per source.
REQ-010 CPU_IRQ_RAISE  output  NUM_SRC  one-hot request to processor; at most one bit high.
REQ-011 CPU_IRQ_ACK  input  NUM_SRC  processor acknowledge, one-hot, one cycle.

Function
REQ-012 Registers SHALL be: +0 MASK (RW, bit i = 1 enables source i); +1 PENDING (RO, masked SRC_IRQ_RAISE sampled each cycle); +2 STATUS (RO, bit7 = in service, bits[1:0] = active id); +3 COUNT (RO, 8-bit delivered-interrupt counter, wraps 255 -> 0).
REQ-013 Writes SHALL take effect on the clock edge where BUS_WE = 1 and the address matches; writes to +1..+3 SHALL be ignored; MASK bits above NUM_SRC-1 SHALL read 0.
REQ-014 Reads SHALL be registered: data and drive-enable latched one cycle after a matching address with BUS_WE = 0; BUS_DATA driven while that condition holds, released the cycle after it ends.
REQ-015 FSM states SHALL be IDLE, ASSERT, ACK_SRC, GAP.
REQ-016 IDLE: if any PENDING bit is set, select winner per REQ-021, latch its id, go to ASSERT next cycle; else stay.
REQ-017 ASSERT: CPU_IRQ_RAISE[id] = 1; on CPU_IRQ_ACK[id] = 1 go to ACK_SRC; ACKs on other bits SHALL be ignored.
REQ-018 ACK_SRC: SRC_IRQ_ACK[id] = 1 for exactly this cycle; increment COUNT; go to GAP.
REQ-019 GAP: one idle cycle so the source can drop its request; return to IDLE.
REQ-020 Latency: pending at cycle N in IDLE -> CPU_IRQ_RAISE high at N+1; CPU ack at M -> SRC_IRQ_ACK at M+1; earliest next CPU_IRQ_RAISE at M+4.
REQ-021 Arbitration without REQ-027: fixed priority, lowest index wins.
REQ-022 Clearing the MASK bit of the source in service SHALL NOT retract the request; delivery completes normally.
REQ-023 A source dropping its request during ASSERT SHALL NOT retract it; the controller holds the request until the CPU acks.
REQ-024 New requests arriving during service SHALL stay pending and be arbitrated in the next IDLE.
REQ-025 A bus write and a state transition in the same cycle SHALL both take effect; a MASK write affects arbitration from the next cycle.

Reset
REQ-026 On RESET: state IDLE; MASK = all ones; COUNT = 0; CPU_IRQ_RAISE = 0; SRC_IRQ_ACK = 0; BUS_DATA high-Z; round-robin pointer = 0. Reset during ASSERT SHALL abandon the interrupt without issuing SRC_IRQ_ACK.

Configuration
REQ-027 Macro IRQ_ROUND_ROBIN_EN: when defined, arbitration is round-robin, searching upward from (last serviced id + 1) mod NUM_SRC, and STATUS bit6 reads 1; when undefined, fixed priority per REQ-021 and bit6 reads 0.

Structure
REQ-028 Package irq_pkg SHALL hold the FSM state enum, register offset constants (MASK, PENDING, STATUS, COUNT) and default BASE_ADDR.
REQ-029 The winner-select logic SHALL be a separate sub-module irq_arbiter (inputs: pending vector and pointer; outputs: valid and id).

Verification
REQ-030 Raise src1 only -> CPU_IRQ_RAISE = 3'b010 next cycle; CPU_IRQ_ACK = 3'b010 -> SRC_IRQ_ACK = 3'b010 one cycle later, for one cycle; COUNT reads 1.
REQ-031 Raise src0 and src2 together in fixed mode -> src0 served first, then src2; COUNT = 2.
REQ-032 IRQ_ROUND_ROBIN_EN defined, all three held continuously -> service order 0, 1, 2, 0.
REQ-033 Write MASK = 8'h01 at 0xD0, raise src1 -> no CPU request; PENDING reads 0; write MASK = 8'h07 -> src1 delivered.
REQ-034 Assert RESET during ASSERT for src2 -> CPU_IRQ_RAISE = 0 next cycle, no SRC_IRQ_ACK, MASK reads 8'h07.
REQ-035 256 serviced interrupts -> COUNT reads 0; a read at 0xD3 drives BUS_DATA one cycle after the address is presented, then high-Z.
